stone_renderer: RTL and testbench

Per-frame renderer for the item RAM that the rope controller reads and rewrites. On each frame `start` pulse it walks stone indices 0..quantity-1 and fetches each 32-bit record through the shared RAM read port. It erases each stone's previously drawn 16x16 square and plots the square at the current position into the VGA adapter, one pixel per clock. It sits upstream of the rope controller: it drives `draw_stone_flag`/`draw_index`, which make the rope stall and hand over the RAM read address. It consumes the same RAM `q` bus.

---
 rtl/stone_renderer_pkg.sv | 44 ++++
 rtl/stone_renderer_sprite_scanner.sv | 114 +++++++++++
 rtl/stone_renderer.sv | 224 ++++++++++++++++++++++
 tb/tb_stone_renderer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stone_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stone_renderer_pkg
// Description : Shared definitions for the stone renderer. Holds the item
//               record field positions (the rope controller uses the same
//               ones), the colour constants, the screen limits and the
//               renderer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package stone_renderer_pkg;

  // Item record layout
  localparam int C_REC_X_MSB    = 31;
  localparam int C_REC_X_LSB    = 23;
  localparam int C_REC_Y_MSB    = 18;
  localparam int C_REC_Y_LSB    = 11;
  localparam int C_REC_TYPE_MSB = 3;
  localparam int C_REC_TYPE_LSB = 2;
  localparam int C_REC_VIS_BIT  = 1;
  localparam int C_REC_MOV_BIT  = 0;

  // Colours
  localparam logic [2:0] C_BG_COLOUR      = 3'b000;
  localparam logic [2:0] C_STONE_COLOUR   = 3'b111;
  localparam logic [2:0] C_GOLD_COLOUR    = 3'b110;
  localparam logic [2:0] C_DIAMOND_COLOUR = 3'b011;

  // Visible screen area; pixel sums are formed in 10 bits
  localparam logic [9:0] C_SCREEN_W = 10'd320;
  localparam logic [9:0] C_SCREEN_H = 10'd240;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_LATCH  = 3'd3,
    S_ERASE  = 3'd4,
    S_DRAW   = 3'd5,
    S_UPDATE = 3'd6,
    S_NEXT   = 3'd7
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stone_renderer_sprite_scanner.sv
`default_nettype none
// ============================================================================
// Module      : sprite_scanner
// Description : Walks a SPRITE x SPRITE square one pixel per clock, dx
//               fastest. A load captures the base X/Y and colour and emits
//               pixel 0 on the next cycle; the scan then advances by itself.
//               Pixels falling off the 320x240 screen keep their slot in
//               the scan but are not plotted.
// Ports       : clk/rst        - clock, synchronous active-high reset
//               i_load         - start a new square (wins over a running one)
//               i_base_x/y     - square origin
//               i_colour       - colour for every pixel of the square
//               o_x/o_y/o_colour/o_plot - registered pixel write
//               o_last         - high while the final pixel is on the outputs
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_scanner
  import stone_renderer_pkg::*;
#(
  parameter int SPRITE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [8:0] i_base_x,
  input  logic [7:0] i_base_y,
  input  logic [2:0] i_colour,
  output logic [8:0] o_x,
  output logic [7:0] o_y,
  output logic [2:0] o_colour,
  output logic       o_plot,
  output logic       o_last
);

  localparam int CW = $clog2(SPRITE);
  localparam int NW = 2 * CW;

  logic [NW-1:0] r_cnt;
  logic          r_active;
  logic [8:0]    r_bx;
  logic [7:0]    r_by;
  logic [8:0]    r_x;
  logic [7:0]    r_y;
  logic [2:0]    r_colour;
  logic          r_plot;

  logic [NW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_dx;
  logic [CW-1:0] w_dy;
  logic [8:0]    w_sx;
  logic [7:0]    w_sy;
  logic [9:0]    w_px;
  logic [9:0]    w_py;
  logic          w_on_screen;

  assign w_cnt_nxt = r_cnt + {{(NW-1){1'b0}}, 1'b1};

  // Pixel being placed on the outputs at the next edge: pixel 0 of a fresh
  // load, otherwise the successor of the pixel currently shown.
  always_comb begin
    w_sx = r_bx;
    w_sy = r_by;
    w_dx = w_cnt_nxt[CW-1:0];
    w_dy = w_cnt_nxt[NW-1:CW];
    if (i_load) begin
      w_sx = i_base_x;
      w_sy = i_base_y;
      w_dx = '0;
      w_dy = '0;
    end
  end

  assign w_px        = {1'b0, w_sx} + {{(10-CW){1'b0}}, w_dx};
  assign w_py        = {2'b00, w_sy} + {{(10-CW){1'b0}}, w_dy};
  assign w_on_screen = (w_px < C_SCREEN_W) && (w_py < C_SCREEN_H);

  assign o_last   = r_active && (r_cnt == {NW{1'b1}});
  assign o_x      = r_x;
  assign o_y      = r_y;
  assign o_colour = r_colour;
  assign o_plot   = r_plot;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_bx     <= '0;
      r_by     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
    end else if (i_load) begin
      r_cnt    <= '0;
      r_active <= 1'b1;
      r_bx     <= i_base_x;
      r_by     <= i_base_y;
      r_colour <= i_colour;
      r_x      <= w_px[8:0];
      r_y      <= w_py[7:0];
      r_plot   <= w_on_screen;
    end else if (r_active && !o_last) begin
      r_cnt    <= w_cnt_nxt;
      r_x      <= w_px[8:0];
      r_y      <= w_py[7:0];
      r_plot   <= w_on_screen;
    end else begin
      r_active <= 1'b0;
      r_plot   <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stone_renderer.sv
`default_nettype none
// ============================================================================
// Module      : stone_renderer
// Description : Per-frame stone renderer. On start it reads each item record
//               through the shared RAM read port, erases the square drawn
//               for that index last frame when it moved or vanished, and
//               draws the square at the current position.
// Ports       : clock/reset     - clock, synchronous active-high reset
//               start           - frame pulse, accepted only when idle
//               quantity        - live record count, latched on start
//               data            - RAM q, valid one clock after the address
//               draw_stone_flag - this block owns the RAM read address
//               draw_index      - RAM read address
//               vga_x/y/colour/plot - registered pixel write
//               busy            - not idle
//               done            - one-cycle pulse at end of frame pass
// Revision    : 1.0 - initial release
// ============================================================================
module stone_renderer
  import stone_renderer_pkg::*;
#(
  parameter int         MAX_STONES = 16,
  parameter int         SPRITE     = 16,
  parameter logic [2:0] BG_COLOUR  = C_BG_COLOUR,
  parameter logic [2:0] C_STONE    = C_STONE_COLOUR,
  parameter logic [2:0] C_GOLD     = C_GOLD_COLOUR,
  parameter logic [2:0] C_DIAMOND  = C_DIAMOND_COLOUR,
  parameter int         IDX_W      = $clog2(MAX_STONES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [IDX_W-1:0] quantity,
  input  logic [31:0]      data,
  output logic             draw_stone_flag,
  output logic [IDX_W-1:0] draw_index,
  output logic [8:0]       vga_x,
  output logic [7:0]       vga_y,
  output logic [2:0]       vga_colour,
  output logic             vga_plot,
  output logic             busy,
  output logic             done
);

  function automatic logic [2:0] f_type_colour(input logic [1:0] t);
    case (t)
      2'b00:   return C_STONE;
      2'b01:   return C_GOLD;
      default: return C_DIAMOND;
    endcase
  endfunction

  state_t           r_state;
  logic [IDX_W-1:0] r_qty;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_index;
  logic             r_flag;
  logic             r_busy;
  logic             r_done;
  logic [8:0]       r_x;
  logic [7:0]       r_y;
  logic [1:0]       r_type;
  logic             r_vis;

  // Shadow of what was drawn last frame, kept in flops so reset can
  // invalidate every entry in one cycle.
  logic [MAX_STONES-1:0] r_sh_valid;
  logic [8:0]            r_sh_x [MAX_STONES];
  logic [7:0]            r_sh_y [MAX_STONES];

  logic [8:0]     w_d_x;
  logic [7:0]     w_d_y;
  logic [1:0]     w_d_type;
  logic           w_d_vis;
  logic           w_unused_bits;
  logic           w_erase;
  logic [IDX_W:0] w_idx_nxt;
  logic           w_more;
  logic           w_load;
  logic [8:0]     w_base_x;
  logic [7:0]     w_base_y;
  logic [2:0]     w_load_colour;
  logic           w_scan_last;

  assign w_d_x         = data[C_REC_X_MSB:C_REC_X_LSB];
  assign w_d_y         = data[C_REC_Y_MSB:C_REC_Y_LSB];
  assign w_d_type      = data[C_REC_TYPE_MSB:C_REC_TYPE_LSB];
  assign w_d_vis       = data[C_REC_VIS_BIT];
  assign w_unused_bits = ^{data[22:19], data[10:4], data[C_REC_MOV_BIT]};

  // Erase only what was actually drawn and is now stale.
  assign w_erase = r_sh_valid[r_idx] &&
                   (!w_d_vis || (w_d_x != r_sh_x[r_idx]) || (w_d_y != r_sh_y[r_idx]));

  assign w_idx_nxt = {1'b0, r_idx} + {{IDX_W{1'b0}}, 1'b1};
  assign w_more    = w_idx_nxt < {1'b0, r_qty};

  // Scanner load points: leaving LATCH (erase or draw, decided from the live
  // RAM word) and the last erase pixel chaining straight into the draw.
  always_comb begin
    w_load        = 1'b0;
    w_base_x      = w_d_x;
    w_base_y      = w_d_y;
    w_load_colour = f_type_colour(w_d_type);
    case (r_state)
      S_LATCH: begin
        w_load = w_erase || w_d_vis;
        if (w_erase) begin
          w_base_x      = r_sh_x[r_idx];
          w_base_y      = r_sh_y[r_idx];
          w_load_colour = BG_COLOUR;
        end
      end
      S_ERASE: begin
        w_load        = w_scan_last && r_vis;
        w_base_x      = r_x;
        w_base_y      = r_y;
        w_load_colour = f_type_colour(r_type);
      end
      default: ;
    endcase
  end

  sprite_scanner #(
    .SPRITE(SPRITE)
  ) u_scan (
    .clk      (clock),
    .rst      (reset),
    .i_load   (w_load),
    .i_base_x (w_base_x),
    .i_base_y (w_base_y),
    .i_colour (w_load_colour),
    .o_x      (vga_x),
    .o_y      (vga_y),
    .o_colour (vga_colour),
    .o_plot   (vga_plot),
    .o_last   (w_scan_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_qty      <= '0;
      r_idx      <= '0;
      r_index    <= '0;
      r_flag     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_type     <= '0;
      r_vis      <= 1'b0;
      r_sh_valid <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_qty  <= quantity;
            r_idx  <= '0;
            r_busy <= 1'b1;
            if (quantity == '0) begin
              r_state <= S_NEXT;
            end else begin
              r_state <= S_ADDR;
              r_flag  <= 1'b1;
              r_index <= '0;
            end
          end
        end
        S_ADDR:  r_state <= S_WAIT;
        S_WAIT:  r_state <= S_LATCH;
        S_LATCH: begin
          r_flag <= 1'b0;
          r_x    <= w_d_x;
          r_y    <= w_d_y;
          r_type <= w_d_type;
          r_vis  <= w_d_vis;
          if (w_erase)      r_state <= S_ERASE;
          else if (w_d_vis) r_state <= S_DRAW;
          else              r_state <= S_UPDATE;
        end
        S_ERASE: begin
          if (w_scan_last) r_state <= r_vis ? S_DRAW : S_UPDATE;
        end
        S_DRAW: begin
          if (w_scan_last) r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          r_sh_valid[r_idx] <= r_vis;
          r_state           <= S_NEXT;
        end
        S_NEXT: begin
          if (w_more) begin
            r_idx   <= w_idx_nxt[IDX_W-1:0];
            r_index <= w_idx_nxt[IDX_W-1:0];
            r_flag  <= 1'b1;
            r_state <= S_ADDR;
          end else begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Position part of the shadow needs no reset; the valid bits gate it.
  always_ff @(posedge clock) begin
    if ((r_state == S_UPDATE) && r_vis) begin
      r_sh_x[r_idx] <= r_x;
      r_sh_y[r_idx] <= r_y;
    end
  end

  assign draw_stone_flag = r_flag;
  assign draw_index      = r_index;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_stone_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stone_renderer
// Description : Self-checking bench for stone_renderer. A frame model builds
//               the expected per-cycle output timeline from the record RAM
//               and its own copy of last-frame positions; every cycle of a
//               frame is compared against it, and per-frame totals are
//               compared against hand-computed figures.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stone_renderer;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  quantity;
  logic [31:0] ram_q;
  logic        draw_stone_flag;
  logic [3:0]  draw_index;
  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic        busy;
  logic        done;

  stone_renderer dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .quantity        (quantity),
    .data            (ram_q),
    .draw_stone_flag (draw_stone_flag),
    .draw_index      (draw_index),
    .vga_x           (vga_x),
    .vga_y           (vga_y),
    .vga_colour      (vga_colour),
    .vga_plot        (vga_plot),
    .busy            (busy),
    .done            (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Item RAM with one clock read latency
  logic [31:0] mem [16];
  always @(posedge clock) ram_q <= mem[draw_index];

  typedef struct {
    bit flag;
    int idx;
    bit plot;
    int x;
    int y;
    int col;
    bit busy;
    bit done;
  } exp_t;

  exp_t q[$];

  // Model's view of what is on screen per index
  bit m_valid [16];
  int m_x [16];
  int m_y [16];

  int n_checks;
  int n_fail;

  // Per-frame observations
  int n_plot, n_bg, flag_cycles, max_run, done_lat;
  int first_x, first_y, first_col, last_x, last_y, last_col;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp_v, $time);
    end
  endtask

  function automatic logic [31:0] mk_rec(input int x, input int y, input int t,
                                         input bit vis, input bit mov);
    logic [8:0] xv;
    logic [7:0] yv;
    logic [1:0] tv;
    xv = x[8:0];
    yv = y[7:0];
    tv = t[1:0];
    return {xv, 4'b0000, yv, 7'b0000000, tv, vis, mov};
  endfunction

  function automatic int type_colour(input int t);
    if (t == 0) return 7;
    if (t == 1) return 6;
    return 3;
  endfunction

  task automatic push_plain(input bit flag, input int idx, input bit bsy, input bit dn);
    exp_t e;
    e.flag = flag; e.idx = idx; e.plot = 1'b0; e.x = 0; e.y = 0; e.col = 0;
    e.busy = bsy; e.done = dn;
    q.push_back(e);
  endtask

  task automatic push_square(input int bx, input int by, input int col);
    exp_t e;
    for (int dy = 0; dy < 16; dy++) begin
      for (int dx = 0; dx < 16; dx++) begin
        e.flag = 1'b0; e.idx = 0; e.busy = 1'b1; e.done = 1'b0;
        e.x = bx + dx; e.y = by + dy; e.col = col;
        e.plot = (e.x < 320) && (e.y < 240);
        q.push_back(e);
      end
    end
  endtask

  // Expected timeline starting with the cycle after start is accepted
  task automatic build_model(input int qty);
    logic [31:0] r;
    int x, y, t;
    bit vis, er;
    q.delete();
    if (qty == 0) push_plain(1'b0, 0, 1'b1, 1'b0);
    for (int i = 0; i < qty; i++) begin
      r   = mem[i];
      x   = int'(r[31:23]);
      y   = int'(r[18:11]);
      t   = int'(r[3:2]);
      vis = r[1];
      for (int k = 0; k < 3; k++) push_plain(1'b1, i, 1'b1, 1'b0);
      er = m_valid[i] && (!vis || x != m_x[i] || y != m_y[i]);
      if (er)  push_square(m_x[i], m_y[i], 0);
      if (vis) push_square(x, y, type_colour(t));
      push_plain(1'b0, 0, 1'b1, 1'b0);
      push_plain(1'b0, 0, 1'b1, 1'b0);
      m_valid[i] = vis;
      if (vis) begin
        m_x[i] = x;
        m_y[i] = y;
      end
    end
    push_plain(1'b0, 0, 1'b0, 1'b1);
  endtask

  task automatic run_frame(input int qty, input bit poke);
    exp_t e;
    int len, run;
    @(negedge clock);
    quantity = qty[3:0];
    start    = 1'b1;
    build_model(qty);
    len = q.size();
    n_plot = 0; n_bg = 0; flag_cycles = 0; max_run = 0; done_lat = -1; run = 0;
    first_x = -1; first_y = -1; first_col = -1; last_x = -1; last_y = -1; last_col = -1;
    @(posedge clock);
    #1;
    start = 1'b0;
    if (poke) quantity = 4'd15;
    for (int cyc = 1; cyc <= len; cyc++) begin
      @(negedge clock);
      if (poke && cyc == 5) start = 1'b1;
      if (poke && cyc == 6) start = 1'b0;
      e = q.pop_front();
      chk("flag", int'(draw_stone_flag), int'(e.flag));
      chk("busy", int'(busy), int'(e.busy));
      chk("done", int'(done), int'(e.done));
      chk("plot", int'(vga_plot), int'(e.plot));
      if (e.flag) chk("draw_index", int'(draw_index), e.idx);
      if (e.plot) begin
        chk("vga_x", int'(vga_x), e.x);
        chk("vga_y", int'(vga_y), e.y);
        chk("vga_colour", int'(vga_colour), e.col);
      end
      if (vga_plot) begin
        n_plot++;
        if (vga_colour == 3'd0) n_bg++;
        if (first_x < 0) begin
          first_x = int'(vga_x); first_y = int'(vga_y); first_col = int'(vga_colour);
        end
        last_x = int'(vga_x); last_y = int'(vga_y); last_col = int'(vga_colour);
      end
      if (draw_stone_flag) begin
        flag_cycles++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (done && done_lat < 0) done_lat = cyc;
    end
    start = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_after_frame", int'({busy, done, vga_plot, draw_stone_flag}), 0);
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    quantity = 4'd0;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'd0;
      m_valid[i] = 1'b0;
      m_x[i] = 0;
      m_y[i] = 0;
    end
    repeat (3) @(negedge clock);
    chk("reset_flag", int'(draw_stone_flag), 0);
    chk("reset_index", int'(draw_index), 0);
    chk("reset_vga", int'({vga_x, vga_y, vga_colour, vga_plot}), 0);
    chk("reset_busy_done", int'({busy, done}), 0);
    reset = 1'b0;

    // Single gold stone
    mem[0] = mk_rec(40, 100, 1, 1'b1, 1'b0);
    run_frame(1, 1'b0);
    chk("gold_plots", n_plot, 256);
    chk("gold_flag_cycles", flag_cycles, 3);
    chk("gold_flag_run", max_run, 3);
    chk("gold_first", first_x * 1000 + first_y, 40100);
    chk("gold_first_col", first_col, 6);
    chk("gold_last", last_x * 1000 + last_y, 55115);
    chk("gold_done_latency", done_lat, 262);

    // Move right by 4 (moving bit set, must be ignored)
    mem[0] = mk_rec(44, 100, 1, 1'b1, 1'b1);
    run_frame(1, 1'b0);
    chk("move_plots", n_plot, 512);
    chk("move_bg_plots", n_bg, 256);
    chk("move_first", first_x * 1000 + first_y, 40100);
    chk("move_last", last_x * 1000 + last_y, 59115);
    chk("move_done_latency", done_lat, 518);

    // Same position again
    run_frame(1, 1'b0);
    chk("still_plots", n_plot, 256);
    chk("still_bg_plots", n_bg, 0);

    // Stone becomes invisible
    mem[0] = mk_rec(44, 100, 1, 1'b0, 1'b0);
    run_frame(1, 1'b0);
    chk("hide_plots", n_plot, 256);
    chk("hide_bg_plots", n_bg, 256);
    run_frame(1, 1'b0);
    chk("gone_plots", n_plot, 0);
    chk("gone_done_latency", done_lat, 6);

    // Three stones with clipping; start and quantity poked mid-frame
    mem[0] = mk_rec(310, 230, 0, 1'b1, 1'b0);
    mem[1] = mk_rec(0, 0, 2, 1'b1, 1'b0);
    mem[2] = mk_rec(200, 50, 3, 1'b1, 1'b1);
    run_frame(3, 1'b1);
    chk("clip_plots", n_plot, 612);
    chk("clip_flag_run", max_run, 3);
    chk("clip_flag_cycles", flag_cycles, 9);

    // Reset at pixel 100 of the draw at (100,60)
    mem[0] = mk_rec(100, 60, 2, 1'b1, 1'b0);
    @(negedge clock);
    quantity = 4'd3;
    start    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1000 && !found; c++) begin
      @(negedge clock);
      if (vga_plot && vga_x == 9'd104 && vga_y == 8'd66 && vga_colour == 3'd3) found = 1'b1;
    end
    chk("pixel100_reached", int'(found), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("midreset_vga", int'({vga_x, vga_y, vga_colour, vga_plot}), 0);
    chk("midreset_ctrl", int'({draw_stone_flag, draw_index, busy, done}), 0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;

    // After reset nothing is erased
    run_frame(3, 1'b0);
    chk("post_reset_bg_plots", n_bg, 0);
    chk("post_reset_plots", n_plot, 768);

    // Empty frame
    run_frame(0, 1'b0);
    chk("empty_plots", n_plot, 0);
    chk("empty_flags", flag_cycles, 0);
    chk("empty_done_latency", done_lat, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
